cv32e40s_dbg_trace_buf: RTL and testbench

CV32E40S_DBG_TRACE_BUF -- requirements
Module: cv32e40s_dbg_trace_buf

---
 rtl/cv32e40s_pkg.sv | 43 ++++
 rtl/cv32e40s_dbg_trace_fifo.sv | 66 ++++++
 rtl/cv32e40s_dbg_trace_buf.sv | 125 ++++++++++++
 tb/tb_cv32e40s_dbg_trace_buf.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types for the debug trace buffer: register address, opcode decode,
// trace entry layout and trace-buffer FSM state encoding.
package cv32e40s_pkg;

    typedef logic [4:0] rf_addr_t;

    // Trace entries reserve room for the widest register-file configuration;
    // unused read-port slots are stored as zero.
    localparam int unsigned DBG_TRACE_MAX_RF_PORTS = 3;

    typedef enum logic [6:0] {
        OPCODE_LOAD     = 7'h03,
        OPCODE_MISC_MEM = 7'h0F,
        OPCODE_OPIMM    = 7'h13,
        OPCODE_AUIPC    = 7'h17,
        OPCODE_STORE    = 7'h23,
        OPCODE_AMO      = 7'h2F,
        OPCODE_OP       = 7'h33,
        OPCODE_LUI      = 7'h37,
        OPCODE_BRANCH   = 7'h63,
        OPCODE_JALR     = 7'h67,
        OPCODE_JAL      = 7'h6F,
        OPCODE_SYSTEM   = 7'h73
    } opcode_e;

    typedef enum logic [1:0] {
        DBG_TRACE_IDLE   = 2'd0,
        DBG_TRACE_ARMED  = 2'd1,
        DBG_TRACE_FROZEN = 2'd2
    } dbg_trace_state_e;

    typedef struct packed {
        logic [31:0]                                instr;
        logic                                       is_compressed;
        opcode_e                                    opcode;
        logic [DBG_TRACE_MAX_RF_PORTS-1:0]          rf_re;
        rf_addr_t [DBG_TRACE_MAX_RF_PORTS-1:0]      rf_raddr;
        logic                                       rf_we;
        rf_addr_t                                   rf_waddr;
        logic                                       illegal_insn;
    } dbg_trace_t;

endpackage

// File: rtl/cv32e40s_dbg_trace_fifo.sv
// Circular storage for trace entries: write/read pointers wrap modulo DEPTH,
// level tracks occupancy. The caller only pushes when room exists (or a pop
// frees a slot the same cycle) and only pops when non-empty.
module cv32e40s_dbg_trace_fifo
    import cv32e40s_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  dbg_trace_t                 wdata_i,
    input  logic                       pop_i,
    output dbg_trace_t                 rdata_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    dbg_trace_t         mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   level_q, level_d;

    // Clear discards any push/pop requested in the same cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PTR_W'(1);
            if (pop_i)  rptr_d = rptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/cv32e40s_dbg_trace_buf.sv
// Debug trace buffer: captures decode-stage instruction fields while armed,
// optionally freezes on an illegal instruction, and streams entries out.
module cv32e40s_dbg_trace_buf
    import cv32e40s_pkg::*;
#(
    parameter int unsigned REGFILE_NUM_READ_PORTS = 2,
    parameter int unsigned DEPTH                  = 8,
    parameter bit          FREEZE_ON_ILLEGAL      = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   enable_i,
    input  logic                                   clear_i,
    input  logic                                   cap_valid_i,
    input  logic [31:0]                            instr_i,
    input  logic                                   is_compressed_i,
    input  logic [REGFILE_NUM_READ_PORTS-1:0]      rf_re_i,
    input  rf_addr_t [REGFILE_NUM_READ_PORTS-1:0]  rf_raddr_i,
    input  logic                                   rf_we_i,
    input  rf_addr_t                               rf_waddr_i,
    input  logic                                   illegal_insn_i,
    output logic                                   trace_valid_o,
    input  logic                                   trace_ready_i,
    output dbg_trace_t                             trace_o,
    output logic [$clog2(DEPTH):0]                 level_o,
    output logic                                   overflow_o,
    output logic [15:0]                            drop_cnt_o,
    output logic                                   frozen_o,
    output dbg_trace_state_e                       dbg_state_o
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE   = 2'(DBG_TRACE_IDLE);
    localparam logic [1:0] ST_ARMED  = 2'(DBG_TRACE_ARMED);
    localparam logic [1:0] ST_FROZEN = 2'(DBG_TRACE_FROZEN);

    logic [1:0]       state_q, state_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [LVL_W-1:0] level;
    logic             capture, pop, push, drop;
    dbg_trace_t       wentry;

    // Valid/ready: an entry transfers on any cycle where trace_valid_o and
    // trace_ready_i are both high; trace_o holds while valid is not accepted.
    assign trace_valid_o = (level != '0);
    assign pop           = trace_valid_o && trace_ready_i;
    assign capture       = (state_q == ST_ARMED) && cap_valid_i && !clear_i;
    assign push          = capture && ((level < LVL_W'(DEPTH)) || pop);
    assign drop          = capture && !push;

    always_comb begin
        wentry               = '0;
        wentry.instr         = instr_i;
        wentry.is_compressed = is_compressed_i;
        wentry.opcode        = opcode_e'(instr_i[6:0]);
        wentry.rf_we         = rf_we_i;
        wentry.rf_waddr      = rf_waddr_i;
        wentry.illegal_insn  = illegal_insn_i;
        for (int i = 0; i < REGFILE_NUM_READ_PORTS; i++) begin
            wentry.rf_re[i]    = rf_re_i[i];
            wentry.rf_raddr[i] = rf_raddr_i[i];
        end
    end

    // Freezing counts the illegal capture even when it was dropped for full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_ARMED;
            ST_ARMED: begin
                if (FREEZE_ON_ILLEGAL && capture && illegal_insn_i) state_d = ST_FROZEN;
                else if (!enable_i)                                 state_d = ST_IDLE;
            end
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
        endcase
        if (clear_i) state_d = ST_IDLE;
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    cv32e40s_dbg_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear_i),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (trace_o),
        .level_o (level)
    );

    assign level_o     = level;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign frozen_o    = (state_q == ST_FROZEN);
    assign dbg_state_o = dbg_trace_state_e'(state_q);

endmodule

// File: tb/tb_cv32e40s_dbg_trace_buf.sv
// Directed bench for cv32e40s_dbg_trace_buf: ordered capture, overflow and
// drop counting, full push+pop, illegal freeze, saturation and async reset.
module tb_cv32e40s_dbg_trace_buf;
  import cv32e40s_pkg::*;

  localparam int NP    = 2;
  localparam int DEPTH = 8;
  localparam int TW    = $bits(dbg_trace_t);

  logic                 clk;
  logic                 rst_n;
  logic                 enable_i;
  logic                 clear_i;
  logic                 cap_valid_i;
  logic [31:0]          instr_i;
  logic                 is_compressed_i;
  logic [NP-1:0]        rf_re_i;
  rf_addr_t [NP-1:0]    rf_raddr_i;
  logic                 rf_we_i;
  rf_addr_t             rf_waddr_i;
  logic                 illegal_insn_i;
  logic                 trace_valid_o;
  logic                 trace_ready_i;
  dbg_trace_t           trace_o;
  logic [3:0]           level_o;
  logic                 overflow_o;
  logic [15:0]          drop_cnt_o;
  logic                 frozen_o;
  dbg_trace_state_e     dbg_state_o;

  cv32e40s_dbg_trace_buf #(
    .REGFILE_NUM_READ_PORTS (NP),
    .DEPTH                  (DEPTH),
    .FREEZE_ON_ILLEGAL      (1'b1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable_i),
    .clear_i         (clear_i),
    .cap_valid_i     (cap_valid_i),
    .instr_i         (instr_i),
    .is_compressed_i (is_compressed_i),
    .rf_re_i         (rf_re_i),
    .rf_raddr_i      (rf_raddr_i),
    .rf_we_i         (rf_we_i),
    .rf_waddr_i      (rf_waddr_i),
    .illegal_insn_i  (illegal_insn_i),
    .trace_valid_o   (trace_valid_o),
    .trace_ready_i   (trace_ready_i),
    .trace_o         (trace_o),
    .level_o         (level_o),
    .overflow_o      (overflow_o),
    .drop_cnt_o      (drop_cnt_o),
    .frozen_o        (frozen_o),
    .dbg_state_o     (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [TW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic dbg_trace_t mk(input logic [31:0] ins, input logic [NP-1:0] re,
                                    input opcode_e op, input logic ill);
    dbg_trace_t t;
    t               = '0;
    t.instr         = ins;
    t.is_compressed = 1'b0;
    t.opcode        = op;
    t.rf_re         = {1'b0, re};
    t.rf_raddr[0]   = ins[19:15];
    t.rf_raddr[1]   = ins[24:20];
    t.rf_we         = 1'b1;
    t.rf_waddr      = ins[11:7];
    t.illegal_insn  = ill;
    return t;
  endfunction

  // driver
  task automatic set_cap(input logic [31:0] ins, input logic [NP-1:0] re, input logic ill);
    cap_valid_i     = 1'b1;
    instr_i         = ins;
    is_compressed_i = 1'b0;
    rf_re_i         = re;
    rf_raddr_i[0]   = ins[19:15];
    rf_raddr_i[1]   = ins[24:20];
    rf_we_i         = 1'b1;
    rf_waddr_i      = ins[11:7];
    illegal_insn_i  = ill;
  endtask

  task automatic check_head(input string tag);
    chk({tag, "_valid"}, 128'(trace_valid_o), 128'd1);
    if (exp_q.size() > 0) chk({tag, "_entry"}, 128'(trace_o), 128'(exp_q[0]));
    else chk({tag, "_expq_empty"}, 128'(exp_q.size()), 128'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_level"},  128'(level_o),       128'd0);
    chk({tag, "_valid"},  128'(trace_valid_o), 128'd0);
    chk({tag, "_ovf"},    128'(overflow_o),    128'd0);
    chk({tag, "_drop"},   128'(drop_cnt_o),    128'd0);
    chk({tag, "_frozen"}, 128'(frozen_o),      128'd0);
    chk({tag, "_state"},  128'(dbg_state_o),   128'(DBG_TRACE_IDLE));
  endtask

  initial begin
    logic [31:0] ins;
    rst_n = 1'b0; enable_i = 1'b0; clear_i = 1'b0; cap_valid_i = 1'b0;
    instr_i = '0; is_compressed_i = 1'b0; rf_re_i = '0; rf_raddr_i = '0;
    rf_we_i = 1'b0; rf_waddr_i = '0; illegal_insn_i = 1'b0; trace_ready_i = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // three ordered captures, drained as they arrive
    enable_i = 1'b1;
    tick();
    chk("armed_state", 128'(dbg_state_o), 128'(DBG_TRACE_ARMED));
    trace_ready_i = 1'b1;
    set_cap(32'h0000_0013, 2'b01, 1'b0);
    #1;
    chk("no_bypass_valid", 128'(trace_valid_o), 128'd0);
    exp_q.push_back(mk(32'h0000_0013, 2'b01, OPCODE_OPIMM, 1'b0));
    tick();
    check_head("cap0");
    chk("cap0_level", 128'(level_o), 128'd1);
    set_cap(32'h0000_0093, 2'b10, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(mk(32'h0000_0093, 2'b10, OPCODE_OPIMM, 1'b0));
    tick();
    check_head("cap1");
    chk("cap1_level", 128'(level_o), 128'd1);
    set_cap(32'h0000_0113, 2'b11, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(mk(32'h0000_0113, 2'b11, OPCODE_OPIMM, 1'b0));
    tick();
    check_head("cap2");
    cap_valid_i = 1'b0;
    void'(exp_q.pop_front());
    tick();
    chk("drain3_level", 128'(level_o), 128'd0);
    chk("drain3_valid", 128'(trace_valid_o), 128'd0);

    // overflow: 11 captures into an 8-deep buffer with no reader
    trace_ready_i = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ins = 32'h0000_0033 | (32'(i) << 7) | (32'(i + 1) << 15) | (32'(i + 2) << 20);
      set_cap(ins, 2'b11, 1'b0);
      if (i < DEPTH) exp_q.push_back(mk(ins, 2'b11, OPCODE_OP, 1'b0));
      tick();
    end
    cap_valid_i = 1'b0;
    chk("full_level", 128'(level_o), 128'd8);
    chk("full_ovf",   128'(overflow_o), 128'd1);
    chk("full_drop",  128'(drop_cnt_o), 128'd3);
    check_head("full_head");

    // full buffer: capture and pop in the same cycle
    trace_ready_i = 1'b1;
    set_cap(32'h000A_B037, 2'b01, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(mk(32'h000A_B037, 2'b01, OPCODE_LUI, 1'b0));
    tick();
    cap_valid_i = 1'b0;
    trace_ready_i = 1'b0;
    chk("pushpop_level", 128'(level_o), 128'd8);
    chk("pushpop_drop",  128'(drop_cnt_o), 128'd3);
    trace_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_head($sformatf("drain%0d", i));
      void'(exp_q.pop_front());
      tick();
    end
    chk("drain8_level", 128'(level_o), 128'd0);
    chk("drain8_valid", 128'(trace_valid_o), 128'd0);

    // illegal capture freezes the buffer
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear1_ovf",   128'(overflow_o), 128'd0);
    chk("clear1_drop",  128'(drop_cnt_o), 128'd0);
    chk("clear1_state", 128'(dbg_state_o), 128'(DBG_TRACE_IDLE));
    tick();
    chk("rearm_state", 128'(dbg_state_o), 128'(DBG_TRACE_ARMED));
    trace_ready_i = 1'b0;
    set_cap(32'h0000_0000, 2'b00, 1'b1);
    exp_q.push_back(mk(32'h0000_0000, 2'b00, opcode_e'(7'h00), 1'b1));
    tick();
    chk("ill_frozen", 128'(frozen_o), 128'd1);
    chk("ill_level",  128'(level_o), 128'd1);
    set_cap(32'h0000_0013, 2'b01, 1'b0);
    tick();
    set_cap(32'h0000_0093, 2'b01, 1'b0);
    tick();
    cap_valid_i = 1'b0;
    chk("frz_level",  128'(level_o), 128'd1);
    chk("frz_drop",   128'(drop_cnt_o), 128'd0);
    chk("frz_ovf",    128'(overflow_o), 128'd0);
    check_head("frz_head");
    trace_ready_i = 1'b1;
    void'(exp_q.pop_front());
    tick();
    chk("frz_pop_level",  128'(level_o), 128'd0);
    chk("frz_pop_frozen", 128'(frozen_o), 128'd1);
    enable_i = 1'b0;
    clear_i  = 1'b1;
    tick();
    clear_i = 1'b0;
    check_reset_vals("clear2");

    // drop counter saturation
    trace_ready_i = 1'b0;
    enable_i = 1'b1;
    tick();
    set_cap(32'h0010_0093, 2'b01, 1'b0);
    repeat (DEPTH) tick();
    chk("sat_fill_level", 128'(level_o), 128'd8);
    chk("sat_fill_drop",  128'(drop_cnt_o), 128'd0);
    repeat (65534) tick();
    chk("sat_fffe", 128'(drop_cnt_o), 128'hFFFE);
    tick();
    chk("sat_ffff", 128'(drop_cnt_o), 128'hFFFF);
    repeat (5) tick();
    chk("sat_hold", 128'(drop_cnt_o), 128'hFFFF);
    chk("sat_ovf",  128'(overflow_o), 128'd1);
    cap_valid_i = 1'b0;

    // asynchronous reset mid-stream
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear3_drop", 128'(drop_cnt_o), 128'd0);
    tick();
    set_cap(32'h0000_0013, 2'b01, 1'b0);
    repeat (5) tick();
    cap_valid_i = 1'b0;
    chk("pre_rst_level", 128'(level_o), 128'd5);
    chk("pre_rst_valid", 128'(trace_valid_o), 128'd1);
    #2;
    cap_valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    enable_i = 1'b0;
    cap_valid_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 128'(trace_valid_o), 128'd0);
    chk("post_rst_level", 128'(level_o), 128'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
